// File: rtl/ram_arb2.sv
// ram_arb2: two-master round-robin arbiter sequencing read/write accesses onto a single-port RAM
module ram_arb2 #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          ram_wr_re,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_datain,
  input  logic [DW-1:0] ram_dataout
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_t;
  state_t state, state_nx;
  logic last, owner, win, take;
  assign take = state == IDLE && (req0 || req1);
  assign win = (req0 && req1) ? ~last : req1;
  assign busy = state != IDLE;
  // next state: a write finishes after ISSUE, a read needs the CAPT cycle for the registered RAM output
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (take ? ISSUE : IDLE) :
               state == ISSUE ? (ram_wr_re ? IDLE : CAPT) : IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  // grant, RAM port and read return registers; strobes default low so they pulse for one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= 1'b1;
      owner <= 1'b0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      ram_wr_re <= 1'b0;
      ram_addr <= '0;
      ram_datain <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      ram_wr_re <= 1'b0;
      if (take) begin
        last <= win;
        owner <= win;
        gnt0 <= ~win;
        gnt1 <= win;
        ram_wr_re <= win ? wr1 : wr0;
        ram_addr <= win ? addr1 : addr0;
        ram_datain <= win ? wdata1 : wdata0;
      end
      if (state == CAPT && owner) begin
        rdata1 <= ram_dataout;
        rvalid1 <= 1'b1;
      end
      if (state == CAPT && !owner) begin
        rdata0 <= ram_dataout;
        rvalid0 <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ram_arb2.sv
// tb_ram_arb2: randomized and directed check of ram_arb2 against a transaction-level model
module tb_ram_arb2;
  logic clk = 0, rst = 0;
  logic req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
  logic [4:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic gnt0, gnt1, rvalid0, rvalid1, busy, ram_wr_re;
  logic [7:0] rdata0, rdata1, ram_datain, ram_dataout;
  logic [4:0] ram_addr;
  int n_chk = 0, n_pass = 0;
  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];
  bit m_last, req0_q, req1_q, any, win, w, f0, f1;
  int m_cnt, m_rv0, m_rv1;
  logic [7:0] x0, x1, e_rd0, e_rd1, d;
  logic [4:0] a;

  ram_arb2 dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy), .ram_wr_re(ram_wr_re),
    .ram_addr(ram_addr), .ram_datain(ram_datain), .ram_dataout(ram_dataout)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) begin
    mem[i] = 0;
    ref_mem[i] = 0;
  end

  // the RAM the arbiter fronts: write and registered read on the same edge
  always @(posedge clk) begin
    if (ram_wr_re) mem[ram_addr] <= ram_datain;
    ram_dataout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // model: arbitration edges, grant choice, grant-order memory image and read return timing
  always @(negedge clk) begin
    if (!rst) begin
      m_last = 1; m_cnt = 0; m_rv0 = 0; m_rv1 = 0; e_rd0 = 0; e_rd1 = 0;
    end else begin
      f0 = m_rv0 == 1;
      f1 = m_rv1 == 1;
      if (m_rv0 != 0) m_rv0--;
      if (m_rv1 != 0) m_rv1--;
      if (f0) e_rd0 = x0;
      if (f1) e_rd1 = x1;
      chk("rvalid0", rvalid0, f0);
      chk("rvalid1", rvalid1, f1);
      chk("rdata0", rdata0, e_rd0);
      chk("rdata1", rdata1, e_rd1);
      if (m_cnt == 0) begin
        any = req0_q | req1_q;
        win = (req0_q && req1_q) ? !m_last : req1_q;
        chk("gnt0", gnt0, any && !win);
        chk("gnt1", gnt1, any && win);
        w = win ? wr1 : wr0;
        a = win ? addr1 : addr0;
        d = win ? wdata1 : wdata0;
        chk("ram_wr_re", ram_wr_re, any && w);
        if (any) begin
          chk("ram_addr", ram_addr, a);
          if (w) begin
            chk("ram_datain", ram_datain, d);
            ref_mem[a] = d;
          end else if (win) begin
            m_rv1 = 2; x1 = ref_mem[a];
          end else begin
            m_rv0 = 2; x0 = ref_mem[a];
          end
          m_last = win;
          m_cnt = w ? 1 : 2;
        end
      end else begin
        chk("gnt0_busy", gnt0, 0);
        chk("gnt1_busy", gnt1, 0);
        chk("ram_wr_re_busy", ram_wr_re, 0);
        m_cnt--;
      end
      chk("busy", busy, m_cnt != 0);
    end
    req0_q = req0;
    req1_q = req1;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, {gnt1, gnt0}, 0);
    chk({tag, "_rvalid"}, {rvalid1, rvalid0}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wr_re"}, ram_wr_re, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_datain"}, ram_datain, 0);
    chk({tag, "_rdata"}, {rdata1, rdata0}, 0);
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0; rst = 0;
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic access(input bit m, input bit wr, input logic [4:0] ad, input logic [7:0] dt);
    bit got = 0;
    if (m) begin wr1 = wr; addr1 = ad; wdata1 = dt; req1 = 1; end
    else begin wr0 = wr; addr0 = ad; wdata0 = dt; req0 = 1; end
    for (int i = 0; i < 16 && !got; i++) begin
      @(posedge clk); #1;
      got = m ? gnt1 : gnt0;
    end
    if (m) req1 = 0; else req0 = 0;
    if (!got) chk(m ? "timeout1" : "timeout0", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    do_reset();
    access(0, 1, 3, 8'hA5);
    access(1, 0, 3, 0);
    idle(3);
    access(0, 1, 0, 8'h11);
    access(1, 1, 1, 8'h22);
    fork
      for (int i = 0; i < 4; i++) access(0, 0, 0, 0);
      for (int j = 0; j < 4; j++) access(1, 0, 1, 0);
    join
    idle(3);
    do_reset();
    fork
      access(0, 1, 7, 8'h3C);
      access(1, 0, 7, 0);
    join
    idle(3);
    wr0 = 0; addr0 = 3; req0 = 1;
    idle(1);
    chk("capt_gnt0", gnt0, 1);
    req0 = 0;
    idle(1);
    rst = 0;
    #1 chk_zero("async_rst");
    idle(1);
    rst = 1;
    fork
      access(0, 0, 7, 0);
      access(1, 0, 3, 0);
    join
    idle(3);
    fork
      access(1, 0, 5, 0);
      begin idle(1); wr0 = 1; addr0 = 9; wdata0 = 8'h77; req0 = 1; idle(1); req0 = 0; end
    join
    idle(4);
    chk("withdraw_mem", mem[9], 0);
    fork
      for (int i = 0; i < 40; i++) begin
        access(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 8'($urandom));
        idle($urandom_range(0, 2));
      end
      for (int j = 0; j < 40; j++) begin
        access(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 8'($urandom));
        idle($urandom_range(0, 2));
      end
    join
    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
